// File: rtl/prover_round_accum_pkg.sv
// Field constants, accumulator state type and round geometry for the sumcheck round accumulator.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package prover_round_accum_pkg;

  // Field definitions: Mersenne-61 prime field.
  localparam int F_NBITS = 61;
  localparam logic [F_NBITS-1:0] F_Q  = {F_NBITS{1'b1}};
  localparam logic [F_NBITS-1:0] F_M1 = F_Q - F_NBITS'(1);

  // Round geometry.
  localparam int nCopyBits    = 4;
  localparam int nExtraRounds = 4;
  localparam int nPoints      = 4;
  localparam int nRounds      = nCopyBits + nExtraRounds;
  localparam int RN_BITS      = $clog2(nRounds + 1);
  // Wide enough to hold the largest gate count, 1 << (nCopyBits-1).
  localparam int GC_BITS      = nCopyBits;

  typedef logic [F_NBITS-1:0] fe_t;
  typedef fe_t [nPoints-1:0]  vals_t;

  typedef enum logic {IDLE, ACCUM} state_e;

  // Gates expected in a round: halves each copy round, then one per extra round.
  function automatic logic [GC_BITS-1:0] gates_for_round(input logic [RN_BITS-1:0] rn);
    logic [GC_BITS-1:0] m;
    m = GC_BITS'(1);
    if (rn < RN_BITS'(nCopyBits)) m = m << (RN_BITS'(nCopyBits - 1) - rn);
    return m;
  endfunction

endpackage

// File: rtl/prover_round_accum_if.sv
// Bundle between the V evaluator / transcript side and the round accumulator.
// Latency: n/a (wiring only).
// Backpressure: none; the evaluator pushes samples, the accumulator never stalls it.
interface prover_round_accum_if;
  import prover_round_accum_pkg::*;

  logic                i_en;
  logic                i_restart;
  vals_t               i_in_vals;
  logic                i_in_valid;
  vals_t               o_sums;
  logic [RN_BITS-1:0]  o_round_num;
  logic                o_ready;
  logic                o_ready_pulse;
  logic                o_err;

  modport master (
    output i_en, i_restart, i_in_vals, i_in_valid,
    input  o_sums, o_round_num, o_ready, o_ready_pulse, o_err
  );

  modport slave (
    input  i_en, i_restart, i_in_vals, i_in_valid,
    output o_sums, o_round_num, o_ready, o_ready_pulse, o_err
  );

endinterface

// File: rtl/prover_round_accum_field_add_acc.sv
// Registered modular accumulator: acc <= clr ? 0 : acc + val mod F_Q.
// Latency: 1 cycle from an add_en sample to the updated sum.
// Backpressure: none; accepts one addend every cycle.
module field_add_acc
  import prover_round_accum_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_add_en,
  input  fe_t  i_val,
  output fe_t  o_sum
);

  fe_t                r_acc;
  logic [F_NBITS:0]   w_sum_wide;
  fe_t                w_sum_mod;

  // Both operands are already reduced, so one conditional subtract suffices.
  assign w_sum_wide = {1'b0, r_acc} + {1'b0, i_val};
  assign w_sum_mod  = (w_sum_wide >= {1'b0, F_Q}) ? F_NBITS'(w_sum_wide - {1'b0, F_Q})
                                                  : w_sum_wide[F_NBITS-1:0];

  // Accumulator register; clear wins over add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_acc <= '0;
    else if (i_clr)    r_acc <= '0;
    else if (i_add_en) r_acc <= w_sum_mod;
  end

  assign o_sum = r_acc;

endmodule

// File: rtl/prover_round_accum.sv
// Sumcheck round accumulator: field-sums per-gate evaluations at {0,1,-1,2} over one round.
// Latency: sums final 1 cycle after the last sample; ready_pulse in that same cycle.
// Backpressure: none; samples outside a round and en during a round are dropped and flagged in err.
module prover_round_accum
  import prover_round_accum_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  prover_round_accum_if.slave bus
);

  state_e              r_state, w_state_nxt;
  logic [GC_BITS-1:0]  r_gate_cnt;
  logic [GC_BITS-1:0]  w_m;
  logic [RN_BITS-1:0]  r_round_num;
  logic                r_started;
  logic                r_err;
  logic                r_pulse;
  logic                w_start;
  logic                w_accept;
  logic                w_done;
  logic                w_err_set;
  logic                w_last_round;
  vals_t               w_sums;

  assign w_m          = gates_for_round(r_round_num);
  assign w_last_round = (r_round_num == RN_BITS'(nRounds - 1));

  // Next-state and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_en) begin
          w_start     = 1'b1;
          w_state_nxt = ACCUM;
          // Running off the end of the round sequence without restart.
          if (r_started && !bus.i_restart && w_last_round) w_err_set = 1'b1;
        end
        if (bus.i_in_valid) w_err_set = 1'b1;
      end
      ACCUM: begin
        if (bus.i_in_valid) begin
          w_accept = 1'b1;
          if (r_gate_cnt == w_m - GC_BITS'(1)) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        if (bus.i_en) w_err_set = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Gate counter, round counter, sticky error and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gate_cnt  <= '0;
      r_round_num <= '0;
      r_started   <= 1'b0;
      r_err       <= 1'b0;
      r_pulse     <= 1'b0;
    end else begin
      if (w_start) begin
        r_gate_cnt  <= '0;
        r_started   <= 1'b1;
        // First round after reset is always round 0.
        r_round_num <= (!r_started || bus.i_restart || w_last_round) ? '0
                                                                      : r_round_num + RN_BITS'(1);
      end else if (w_accept) begin
        r_gate_cnt  <= r_gate_cnt + GC_BITS'(1);
      end
      if (w_err_set) r_err <= 1'b1;
      r_pulse <= w_done;
    end
  end

  for (genvar p = 0; p < nPoints; p++) begin : g_acc
    field_add_acc u_acc (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_start),
      .i_add_en (w_accept),
      .i_val    (bus.i_in_vals[p]),
      .o_sum    (w_sums[p])
    );
  end

  assign bus.o_sums        = w_sums;
  assign bus.o_round_num   = r_round_num;
  assign bus.o_ready       = (r_state == IDLE);
  assign bus.o_ready_pulse = r_pulse;
  assign bus.o_err         = r_err;

endmodule

// File: tb/tb_prover_round_accum.sv
// Bench for the sumcheck round accumulator: round table plus hand-written corner sequences.
// Expected round sums are built with an independent 64-bit modulo model and queued per round.
// Completed rounds are popped from the queue on ready_pulse and compared.
module tb_prover_round_accum;
  import prover_round_accum_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prover_round_accum_if u_if ();

  prover_round_accum u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  typedef struct {
    vals_t              sums;
    logic [RN_BITS-1:0] rn;
  } exp_t;

  typedef struct {
    bit rs;
    int n;
    int mode;
    int exp_rn;
    bit exp_err;
  } vec_t;

  exp_t  sb_q[$];
  vec_t  vecs[11];
  int    checks   = 0;
  int    failures = 0;
  vals_t last_sums;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic fe_t model_add(input fe_t a, input fe_t b);
    logic [63:0] s;
    s = (64'(a) + 64'(b)) % 64'(F_Q);
    return fe_t'(s);
  endfunction

  // Scoreboard consumer and field-range monitor.
  always @(negedge clk) begin : mon
    exp_t e;
    logic big;
    if (!rst) begin
      big = 1'b0;
      for (int p = 0; p < nPoints; p++)
        if (u_if.o_sums[p] >= F_Q) big = 1'b1;
      chk("sum_range", 64'(big), 64'd0);
      if (u_if.o_ready_pulse) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_pulse", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          for (int p = 0; p < nPoints; p++)
            chk($sformatf("sums[%0d]", p), 64'(u_if.o_sums[p]), 64'(e.sums[p]));
          chk("round_num_done", 64'(u_if.o_round_num), 64'(e.rn));
        end
      end
    end
  end

  // Runs one round starting at a negedge; ends on the negedge where ready_pulse shows,
  // or one cycle later when hold is set. en_at inserts a stray en before that gate.
  task automatic run_round(input bit rs, input int n, input int mode, input int exp_rn,
                           input int en_at, input bit hold);
    vals_t v[8];
    vals_t acc;
    exp_t  e;
    u_if.i_en       = 1'b1;
    u_if.i_restart  = rs;
    u_if.i_in_valid = 1'b0;
    @(negedge clk);
    u_if.i_en      = 1'b0;
    u_if.i_restart = 1'b0;
    chk("ready_low", 64'(u_if.o_ready), 64'd0);
    chk("round_num_start", 64'(u_if.o_round_num), 64'(exp_rn));
    acc = '0;
    for (int g = 0; g < n; g++) begin
      for (int p = 0; p < nPoints; p++) begin
        case (mode)
          0:       v[g][p] = fe_t'(16 * g + p + 1);
          1:       v[g][p] = F_M1;
          default: v[g][p] = fe_t'({$urandom, $urandom} % 64'(F_Q));
        endcase
        acc[p] = model_add(acc[p], v[g][p]);
      end
    end
    e.sums = acc;
    e.rn   = RN_BITS'(exp_rn);
    sb_q.push_back(e);
    last_sums = acc;
    for (int g = 0; g < n; g++) begin
      if (g == en_at) begin
        u_if.i_en       = 1'b1;
        u_if.i_in_valid = 1'b0;
        @(negedge clk);
        u_if.i_en = 1'b0;
        chk("busy_after_en", 64'(u_if.o_ready), 64'd0);
        chk("round_num_kept", 64'(u_if.o_round_num), 64'(exp_rn));
      end
      u_if.i_in_vals  = v[g];
      u_if.i_in_valid = 1'b1;
      @(negedge clk);
      if (g == n - 2) chk("pulse_early", 64'(u_if.o_ready_pulse), 64'd0);
    end
    u_if.i_in_valid = 1'b0;
    chk("pulse_on", 64'(u_if.o_ready_pulse), 64'd1);
    chk("ready_on", 64'(u_if.o_ready), 64'd1);
    if (hold) begin
      @(negedge clk);
      chk("pulse_off", 64'(u_if.o_ready_pulse), 64'd0);
    end
  endtask

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench timed out");
  end

  initial begin : main
    u_if.i_en       = 1'b0;
    u_if.i_restart  = 1'b0;
    u_if.i_in_valid = 1'b0;
    u_if.i_in_vals  = '0;

    vecs[0]  = '{1'b1, 8, 0, 0, 1'b0};
    vecs[1]  = '{1'b1, 8, 1, 0, 1'b0};
    vecs[2]  = '{1'b0, 4, 2, 1, 1'b0};
    vecs[3]  = '{1'b0, 2, 2, 2, 1'b0};
    vecs[4]  = '{1'b0, 1, 2, 3, 1'b0};
    vecs[5]  = '{1'b0, 1, 2, 4, 1'b0};
    vecs[6]  = '{1'b0, 1, 2, 5, 1'b0};
    vecs[7]  = '{1'b0, 1, 2, 6, 1'b0};
    vecs[8]  = '{1'b0, 1, 2, 7, 1'b0};
    vecs[9]  = '{1'b0, 8, 2, 0, 1'b1};
    vecs[10] = '{1'b1, 8, 2, 0, 1'b1};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_sums", 64'(|u_if.o_sums), 64'd0);
    chk("rst_round_num", 64'(u_if.o_round_num), 64'd0);
    chk("rst_ready", 64'(u_if.o_ready), 64'd1);
    chk("rst_pulse", 64'(u_if.o_ready_pulse), 64'd0);
    chk("rst_err", 64'(u_if.o_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Round 0, saturation wrap, full round trip, off-the-end wrap, restart.
    for (int i = 0; i < 11; i++) begin
      run_round(vecs[i].rs, vecs[i].n, vecs[i].mode, vecs[i].exp_rn, -1, 1'b1);
      chk($sformatf("err_vec%0d", i), 64'(u_if.o_err), 64'(vecs[i].exp_err));
      if (i == 0) chk("round0_sum0", 64'(last_sums[0]), 64'd456);
      if (i == 1) chk("wrap_sum0", 64'(u_if.o_sums[0]), 64'(F_Q - F_NBITS'(8)));
    end

    // Asynchronous reset part-way through a round.
    u_if.i_en      = 1'b1;
    u_if.i_restart = 1'b1;
    @(negedge clk);
    u_if.i_en      = 1'b0;
    u_if.i_restart = 1'b0;
    for (int g = 0; g < 3; g++) begin
      u_if.i_in_vals  = {4{fe_t'(g + 100)}};
      u_if.i_in_valid = 1'b1;
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_sums", 64'(|u_if.o_sums), 64'd0);
    chk("midrst_ready", 64'(u_if.o_ready), 64'd1);
    chk("midrst_err", 64'(u_if.o_err), 64'd0);
    chk("midrst_round_num", 64'(u_if.o_round_num), 64'd0);
    u_if.i_in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // First en after reset lands on round 0 even without restart.
    run_round(1'b0, 8, 0, 0, -1, 1'b1);
    chk("err_after_rst_round", 64'(u_if.o_err), 64'd0);

    // Sample while idle is dropped and flagged.
    u_if.i_in_vals  = {4{fe_t'(12345)}};
    u_if.i_in_valid = 1'b1;
    @(negedge clk);
    u_if.i_in_valid = 1'b0;
    chk("idle_sample_err", 64'(u_if.o_err), 64'd1);
    for (int p = 0; p < nPoints; p++)
      chk($sformatf("idle_sums[%0d]", p), 64'(u_if.o_sums[p]), 64'(last_sums[p]));
    @(negedge clk);
    // Stray en after 3 of 8 gates is ignored; round finishes after 5 more.
    run_round(1'b1, 8, 2, 0, 3, 1'b1);
    chk("err_stays", 64'(u_if.o_err), 64'd1);

    // Back-to-back rounds: en issued on the ready_pulse cycle.
    run_round(1'b0, 4, 0, 1, -1, 1'b0);
    run_round(1'b0, 2, 2, 2, -1, 1'b0);
    run_round(1'b0, 1, 2, 3, -1, 1'b1);

    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
